simeck32_dec_iter: RTL and testbench
====================================

Name: simeck32_dec_iter

Overview:
- Iterative Simeck32 decryptor: the inverse of the team's 32-round unrolled simeck32 encryptor.
- Accepts one 32-bit ciphertext and a 16-bit key, runs one inverse round per clock, and returns the plaintext.
- Uses a valid/ready handshake on both sides.
- Sits on the receive path; its output must round-trip against the existing encryptor, which is the golden model.

Parameters:
- ROUNDS, 32, number of inverse rounds. Must equal the encryptor's round count.
- WORD, 16, half-block width. Block width is 2*WORD.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ciphertext/key presented
- in_ready  out  1  block can accept a ciphertext
- ct_in  in  32  ciphertext; [31:16]=L, [15:0]=R
- key  in  16  round key, identical for every round
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- pt_out  out  32  plaintext; [31:16]=L, [15:0]=R
- busy  out  1  high while rounds are executing

Behaviour:
- Round function: f(x) = (x & rotl(x,5)) ^ rotl(x,1), on 16 bits, rotates modulo 16.
- Encryptor round (golden reference): (L,R) -> (R ^ f(L) ^ K, L).
- Decrypt round: (L,R) -> (R, L ^ f(R) ^ K). All arithmetic is 16-bit XOR/AND; no carries.
- State machine IDLE -> RUN -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch ct_in into the state register, latch key into the key register, clear the round counter, go to RUN. Changes on ct_in/key after acceptance are ignored.
  - RUN: each cycle, apply one decrypt round and increment the counter. After round ROUNDS (counter == ROUNDS-1 at the edge), go to DONE. in_ready=0, busy=1.
  - DONE: out_valid=1; pt_out holds the state register and stays stable while out_ready=0. On out_ready=1, go to IDLE.
- Latency: acceptance at edge N gives out_valid high after edge N+ROUNDS. Throughput is one block per ROUNDS+2 cycles minimum.
- No overlap: in_ready is low in RUN and DONE. in_valid there is ignored and not stored.
- Counter: $clog2(ROUNDS) bits. It never wraps in use; it is cleared on accept.
- Reset (asynchronous, any time including mid-RUN or DONE):
  - state=IDLE, counter=0, state register=0, key register=0.
  - in_ready=1, out_valid=0, busy=0, pt_out=0.
  - A partial result is discarded, never emitted.
- out_valid and in_ready are never high in the same cycle.

Decomposition:
- Package simeck_pkg holds: WORD, ROUNDS, rotation constants ROT_A=5 and ROT_B=1, the FSM state enum (IDLE/RUN/DONE), and the function f.
- One combinational sub-module, simeck_dec_round: inputs l, r, k; outputs next l, next r. This keeps it symmetric with the encryptor's round module.
- Only the FSM, counter and registers live in the top.

Test Plan:
- Zero vector: key=0x0000, ct=0x00000000 -> pt=0x00000000, out_valid exactly 32 cycles after accept.
- Period-4 vector: key=0xFFFF, ct=0x00000000.
  - State sequence (0,0)->(0,FFFF)->(FFFF,FFFF)->(FFFF,0)->(0,0).
  - Required: final pt=0x00000000, and intermediate round 2 state=0xFFFFFFFF in a white-box check.
- Round trip through the golden encryptor:
  - pt=0x65656877, key=0x1918.
  - pt=0xDEADBEEF, key=0xA5A5.
  - 200 random pairs.
  - Required: decrypted output equals the original pt in every case.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> pt_out stable, in_ready=0, out_valid=1. Release -> IDLE next cycle.
- Ignore while busy: drive in_valid with different ct/key during RUN -> result unaffected, and the second block is not taken until in_ready=1.
- Reset mid-RUN at round 17 -> all outputs at reset values immediately, with no out_valid afterwards. The next accepted block decrypts correctly.

Source files
------------

// File: rtl/simeck_pkg.sv
// simeck_pkg: shared Simeck32 constants, FSM state type and round function
package simeck_pkg;
  localparam int WORD = 16;
  localparam int ROUNDS = 32;
  localparam int ROT_A = 5;
  localparam int ROT_B = 1;
  localparam int CW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [WORD-1:0] f(input logic [WORD-1:0] x);
    return (x & {x[WORD-1-ROT_A:0], x[WORD-1:WORD-ROT_A]}) ^ {x[WORD-1-ROT_B:0], x[WORD-1:WORD-ROT_B]};
  endfunction
endpackage

// File: rtl/simeck_dec_round.sv
// simeck_dec_round: one combinational Simeck32 inverse round
module simeck_dec_round
  import simeck_pkg::*;
(
  input  logic [WORD-1:0] l,
  input  logic [WORD-1:0] r,
  input  logic [WORD-1:0] k,
  output logic [WORD-1:0] nl,
  output logic [WORD-1:0] nr
);
  assign nl = r;
  assign nr = l ^ f(r) ^ k;
endmodule

// File: rtl/simeck32_dec_iter.sv
// simeck32_dec_iter: iterative Simeck32 decryptor, one inverse round per clock
module simeck32_dec_iter
  import simeck_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*WORD-1:0]   ct_in,
  input  logic [WORD-1:0]     key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WORD-1:0]   pt_out,
  output logic                busy
);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WORD-1:0] st;
  logic [WORD-1:0] kr, nl, nr;
  logic last;
  simeck_dec_round u_round (.l(st[2*WORD-1:WORD]), .r(st[WORD-1:0]), .k(kr), .nl(nl), .nr(nr));
  assign last = cnt == CW'(ROUNDS - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      st <= '0;
      kr <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        st <= ct_in;
        kr <= key;
        cnt <= '0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      st <= {nl, nr};
      cnt <= last ? cnt : cnt + 1'b1;
      state <= last ? DONE : RUN;
    end else if (out_ready) begin
      state <= IDLE;
    end
  assign in_ready = state == IDLE;
  assign busy = state == RUN;
  assign out_valid = state == DONE;
  assign pt_out = st;
endmodule

// File: tb/tb_simeck32_dec_iter.sv
// tb_simeck32_dec_iter: directed and round-trip checks against a forward Simeck32 model
module tb_simeck32_dec_iter;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, busy;
  logic [31:0] ct_in = 0, pt_out;
  logic [15:0] key = 0;
  int checks = 0, failures = 0;

  simeck32_dec_iter dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ct_in(ct_in),
    .key(key), .out_valid(out_valid), .out_ready(out_ready), .pt_out(pt_out), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] fm(input logic [15:0] x);
    return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] p, input logic [15:0] k);
    logic [15:0] l, r, t;
    l = p[31:16];
    r = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t = l;
      l = r ^ fm(l) ^ k;
      r = t;
    end
    return {l, r};
  endfunction

  task automatic accept(input logic [31:0] c, input logic [15:0] k);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    ct_in = c;
    key = k;
    in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic decrypt(input logic [31:0] c, input logic [15:0] k, input logic [31:0] exp, input string tag);
    int lat;
    accept(c, k);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 32);
    chk(tag, pt_out, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, seen;
    logic [31:0] p, hold;
    logic [15:0] k;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pt", pt_out, 0);
    @(negedge clk) rst = 0;

    decrypt(32'h0, 16'h0, 32'h0, "zero");

    accept(32'h0, 16'hFFFF);
    repeat (2) @(posedge clk);
    #1 chk("p4_round2", dut.st, 32'hFFFFFFFF);
    wait_out(lat);
    chk("p4_lat", lat + 2, 32);
    chk("p4_pt", pt_out, 32'h0);
    @(posedge clk);
    #1;

    decrypt(enc(32'h65656877, 16'h1918), 16'h1918, 32'h65656877, "vec1");
    decrypt(enc(32'hDEADBEEF, 16'hA5A5), 16'hA5A5, 32'hDEADBEEF, "vec2");

    out_ready = 0;
    accept(enc(32'h12345678, 16'h0F0F), 16'h0F0F);
    wait_out(lat);
    hold = pt_out;
    chk("bp_pt", hold, 32'h12345678);
    repeat (10) begin
      @(posedge clk);
      #1 chk("bp_stable", pt_out, hold);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    out_ready = 1;
    @(posedge clk);
    #1 chk("bp_rel_in_ready", in_ready, 1);
    chk("bp_rel_out_valid", out_valid, 0);

    accept(enc(32'hCAFEF00D, 16'h1357), 16'h1357);
    ct_in = enc(32'h0BADC0DE, 16'h2468);
    key = 16'h2468;
    in_valid = 1;
    wait_out(lat);
    chk("busy_lat", lat, 32);
    chk("busy_pt", pt_out, 32'hCAFEF00D);
    @(posedge clk);
    #1 chk("busy_idle", in_ready, 1);
    @(posedge clk);
    #1 chk("busy_taken", in_ready, 0);
    in_valid = 0;
    wait_out(lat);
    chk("busy_lat2", lat, 32);
    chk("busy_pt2", pt_out, 32'h0BADC0DE);
    @(posedge clk);
    #1;

    accept(enc(32'h55AA33CC, 16'h7777), 16'h7777);
    repeat (17) @(posedge clk);
    #1 rst = 1;
    #1 chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_pt", pt_out, 0);
    @(negedge clk) rst = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("mid_no_out", seen, 0);
    decrypt(enc(32'h89ABCDEF, 16'h4321), 16'h4321, 32'h89ABCDEF, "after_rst");

    for (int i = 0; i < 200; i++) begin
      p = $urandom;
      k = 16'($urandom_range(0, 65535));
      decrypt(enc(p, k), k, p, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
